// File: rtl/clkgen_ctrl_if.sv
// Bus bundle for the clock-generator controller: per-requester run/grant
// handshake, divide-ratio load port and generated-clock status outputs.
// The master side (requesters / bench) drives req, div_val and div_load;
// the slave side (clkgen_ctrl) drives everything else.
interface clkgen_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int DIV_W = 8
);
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  ack;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             rise_stb;
    logic             running;
    logic [15:0]      rise_cnt;

    modport master (
        output req, div_val, div_load,
        input  ack, clk_out, rise_stb, running, rise_cnt
    );

    modport slave (
        input  req, div_val, div_load,
        output ack, clk_out, rise_stb, running, rise_cnt
    );
endinterface

// File: rtl/clkgen_ctrl.sv
// Programmable clock-generator controller.
// Divides clk into a registered clk_out whose high and low phases each last
// half_reg+1 clk cycles, and runs it only while at least one requester holds
// req. Start and stop never produce a short phase, and a new divide ratio
// loaded while running takes effect only on a falling edge of clk_out.
// Optional feature: define CLKGEN_CTRL_RISE_CNT_EN to get a saturating
// 16-bit count of clk_out rising edges on rise_cnt (otherwise tied to 0).
module clkgen_ctrl #(
    parameter int NREQ  = 4,
    parameter int DIV_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    clkgen_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] half_reg;
    logic [DIV_W-1:0] pend_reg;
    logic             pend_vld;
    logic             clk_q;
    logic             clk_nxt;
    logic             rise_q;
    logic [NREQ-1:0]  ack_q;
    logic             rise_evt;
    logic             fall_evt;
    logic             wrap;
    logic             any_req;

    assign any_req = |bus.req;
    assign wrap    = (cnt == half_reg);

    // Next state and phase counter; the plain counter step is the default,
    // individual states override it where the clock must stay parked low.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = wrap ? '0 : cnt + 1'b1;
        clk_nxt   = wrap ? ~clk_q : clk_q;
        rise_evt  = wrap & ~clk_q;
        fall_evt  = wrap & clk_q;
        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                clk_nxt  = 1'b0;
                rise_evt = 1'b0;
                fall_evt = 1'b0;
                if (any_req) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!any_req) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (any_req) begin
                    state_nxt = RUN;
                end else if (!clk_q && ((cnt == '0) || wrap)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    clk_nxt   = 1'b0;
                    rise_evt  = 1'b0;
                    fall_evt  = 1'b0;
                end else if (wrap) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                clk_nxt   = 1'b0;
                rise_evt  = 1'b0;
                fall_evt  = 1'b0;
            end
        endcase
    end

    // State, counter, generated clock, rise strobe and per-requester grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            clk_q  <= 1'b0;
            rise_q <= 1'b0;
            ack_q  <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            clk_q  <= clk_nxt;
            rise_q <= rise_evt;
            ack_q  <= bus.req & (ack_q | {NREQ{rise_evt}});
        end
    end

    // Divide ratio: loads go straight to half_reg when idle, otherwise wait
    // in pend_reg until the next falling edge so no phase is ever cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_reg <= '0;
            pend_reg <= '0;
            pend_vld <= 1'b0;
        end else begin
            if (fall_evt && pend_vld) begin
                half_reg <= pend_reg;
                pend_vld <= 1'b0;
            end
            if (bus.div_load) begin
                pend_reg <= bus.div_val;
                if (state == IDLE) begin
                    half_reg <= bus.div_val;
                end else begin
                    pend_vld <= 1'b1;
                end
            end
        end
    end

`ifdef CLKGEN_CTRL_RISE_CNT_EN
    logic [15:0] rise_cnt_q;

    // Saturating count of clk_out rising edges, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_cnt_q <= 16'h0000;
        end else if (rise_evt && (rise_cnt_q != 16'hFFFF)) begin
            rise_cnt_q <= rise_cnt_q + 16'd1;
        end
    end

    assign bus.rise_cnt = rise_cnt_q;
`else
    assign bus.rise_cnt = 16'h0000;
`endif

    assign bus.ack      = ack_q;
    assign bus.clk_out  = clk_q;
    assign bus.rise_stb = rise_q;
    assign bus.running  = (state != IDLE);

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Testbench for clkgen_ctrl: directed scenarios with hand-computed literal
// expectations, followed by randomized request/load traffic. A phase-level
// reference model (level, cycles left in phase, stopping flag) predicts every
// output and a compare process checks it on each falling clk edge.
module tb_clkgen_ctrl;

    logic clk;
    logic rst_n;

    clkgen_ctrl_if #(.NREQ(4), .DIV_W(8)) bus ();

    clkgen_ctrl #(.NREQ(4), .DIV_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checkCount = 0;
    int errCount   = 0;

    // Reference model state
    int       m_half     = 0;
    int       m_pend     = 0;
    bit       m_pvld     = 0;
    bit       m_active   = 0;
    bit       m_level    = 0;
    bit       m_stopping = 0;
    int       m_left     = 0;
    logic [3:0] m_ack    = 4'b0000;
    bit       m_stb      = 0;
    int       m_rises    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic ld, input logic [7:0] v);
        bus.req      = r;
        bus.div_load = ld;
        bus.div_val  = v;
    endtask

    task automatic stepCycle();
        @(negedge clk);
    endtask

    task automatic loadDiv(input logic [7:0] v);
        applyStimulus(bus.req, 1'b1, v);
        stepCycle();
        applyStimulus(bus.req, 1'b0, v);
    endtask

    task automatic waitRise(input string tag);
        int n;
        n = 0;
        do begin
            stepCycle();
            n++;
        end while ((bus.rise_stb !== 1'b1) && (n < 600));
        checkOutput(tag, 32'(bus.rise_stb), 32'd1);
    endtask

    task automatic waitLevel(input logic lvl, input string tag);
        int n;
        n = 0;
        while ((bus.clk_out !== lvl) && (n < 600)) begin
            stepCycle();
            n++;
        end
        checkOutput(tag, 32'(bus.clk_out), 32'(lvl));
    endtask

    task automatic measurePhase(output int len);
        logic lvl;
        lvl = bus.clk_out;
        len = 1;
        for (int n = 0; n < 600; n++) begin
            stepCycle();
            if (bus.clk_out === lvl) len++;
            else break;
        end
    endtask

    // One clk edge of the reference model, expressed in phases: a phase lasts
    // half+1 cycles, a low phase can be abandoned at its start or end when
    // stopping, a high phase always completes.
    task automatic modelStep();
        bit anyReq;
        bit rise;
        bit fall;
        bit stopNow;
        int oldPend;
        bit oldVld;
        anyReq  = (bus.req != 4'b0000);
        rise    = 0;
        fall    = 0;
        oldPend = m_pend;
        oldVld  = m_pvld;
        if (!m_active) begin
            m_level = 0;
            if (bus.div_load) begin
                m_half = int'(bus.div_val);
                m_pend = int'(bus.div_val);
            end
            if (anyReq) begin
                m_active   = 1;
                m_stopping = 0;
                m_left     = m_half + 1;
            end
        end else begin
            stopNow = m_stopping && !anyReq;
            if (stopNow && !m_level && ((m_left == m_half + 1) || (m_left == 1))) begin
                m_active = 0;
                m_level  = 0;
            end else begin
                if (m_left == 1) begin
                    m_level = !m_level;
                    if (m_level) rise = 1;
                    else fall = 1;
                    if (fall && oldVld) begin
                        m_half = oldPend;
                        m_pvld = 0;
                    end
                    m_left = m_half + 1;
                end else begin
                    m_left--;
                end
                if (stopNow && fall) m_active = 0;
                else m_stopping = !anyReq;
            end
            if (bus.div_load) begin
                m_pend = int'(bus.div_val);
                m_pvld = 1;
            end
        end
        m_ack = bus.req & (m_ack | {4{rise}});
        m_stb = rise;
        if (rise && (m_rises < 65535)) m_rises++;
    endtask

    // Model advances on every clk rise; asynchronous reset clears it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_half = 0; m_pend = 0; m_pvld = 0; m_active = 0; m_level = 0;
            m_stopping = 0; m_left = 0; m_ack = 4'b0000; m_stb = 0; m_rises = 0;
        end else begin
            modelStep();
        end
    end

    // Compare every DUT output against the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("clk_out",  32'(bus.clk_out),  32'(m_level));
        checkOutput("running",  32'(bus.running),  32'(m_active));
        checkOutput("rise_stb", 32'(bus.rise_stb), 32'(m_stb));
        checkOutput("ack",      32'(bus.ack),      32'(m_ack));
`ifdef CLKGEN_CTRL_RISE_CNT_EN
        checkOutput("rise_cnt", 32'(bus.rise_cnt), 32'(m_rises));
`else
        checkOutput("rise_cnt", 32'(bus.rise_cnt), 32'd0);
`endif
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int hLen;
        int lLen;
        int h2Len;
        int idx;
        rst_n = 1'b0;
        applyStimulus(4'b0000, 1'b0, 8'd0);
        repeat (3) stepCycle();
        rst_n = 1'b1;
        checkOutput("reset_clk_out", 32'(bus.clk_out), 32'd0);
        checkOutput("reset_ack",     32'(bus.ack),     32'd0);
        checkOutput("reset_running", 32'(bus.running), 32'd0);
        repeat (50) stepCycle();
        checkOutput("idle_clk_out", 32'(bus.clk_out), 32'd0);
        checkOutput("idle_running", 32'(bus.running), 32'd0);

        // ten periods at clk/2
        loadDiv(8'd0);
        bus.req = 4'b0001;
        for (int k = 0; k < 10; k++) waitRise("div0_rise");
`ifdef CLKGEN_CTRL_RISE_CNT_EN
        checkOutput("rise_cnt_10", 32'(bus.rise_cnt), 32'd10);
`else
        checkOutput("rise_cnt_off", 32'(bus.rise_cnt), 32'd0);
`endif
        bus.req = 4'b0000;
        begin
            int n;
            n = 0;
            do begin stepCycle(); n++; end while ((bus.running !== 1'b0) && (n < 100));
        end
        checkOutput("div0_idle", 32'(bus.running), 32'd0);

        // basic run at 4/4
        loadDiv(8'd3);
        bus.req = 4'b0001;
        stepCycle();
        checkOutput("basic_running", 32'(bus.running), 32'd1);
        checkOutput("basic_low0",    32'(bus.clk_out), 32'd0);
        repeat (3) stepCycle();
        checkOutput("basic_low3", 32'(bus.clk_out), 32'd0);
        stepCycle();
        checkOutput("basic_rise", 32'(bus.clk_out),  32'd1);
        checkOutput("basic_stb",  32'(bus.rise_stb), 32'd1);
        checkOutput("basic_ack",  32'(bus.ack),      32'b0001);
        stepCycle();
        checkOutput("basic_stb_once", 32'(bus.rise_stb), 32'd0);
        repeat (2) stepCycle();
        checkOutput("basic_high3", 32'(bus.clk_out), 32'd1);
        stepCycle();
        checkOutput("basic_fall", 32'(bus.clk_out), 32'd0);

        // glitch-free stop in the second high cycle
        repeat (4) stepCycle();
        checkOutput("stop_rise", 32'(bus.clk_out), 32'd1);
        stepCycle();
        bus.req = 4'b0000;
        stepCycle();
        checkOutput("stop_hold1",   32'(bus.clk_out), 32'd1);
        checkOutput("stop_ack_clr", 32'(bus.ack),     32'd0);
        checkOutput("stop_running", 32'(bus.running), 32'd1);
        stepCycle();
        checkOutput("stop_hold2", 32'(bus.clk_out), 32'd1);
        stepCycle();
        checkOutput("stop_fall", 32'(bus.clk_out), 32'd0);
        checkOutput("stop_idle", 32'(bus.running), 32'd0);
        repeat (10) stepCycle();
        checkOutput("stop_parked", 32'(bus.clk_out), 32'd0);

        // ratio change loaded during a high phase
        bus.req = 4'b0001;
        waitRise("ratio_rise");
        loadDiv(8'd1);
        measurePhase(hLen);
        measurePhase(lLen);
        measurePhase(h2Len);
        checkOutput("ratio_high_len",  32'(hLen + 1), 32'd4);
        checkOutput("ratio_low_len",   32'(lLen),     32'd2);
        checkOutput("ratio_high2_len", 32'(h2Len),    32'd2);

        // second requester joins mid low phase
        bus.req = 4'b0101;
        checkOutput("multi_ack_pre", 32'(bus.ack), 32'b0001);
        stepCycle();
        checkOutput("multi_ack_wait", 32'(bus.ack), 32'b0001);
        stepCycle();
        checkOutput("multi_ack_rise", 32'(bus.ack), 32'b0101);
        bus.req = 4'b0100;
        stepCycle();
        checkOutput("multi_ack_drop0", 32'(bus.ack),     32'b0100);
        checkOutput("multi_running",   32'(bus.running), 32'd1);
        repeat (6) stepCycle();
        waitLevel(1'b1, "multi_wait_high");
        waitLevel(1'b0, "multi_wait_low");
        bus.req = 4'b0000;
        stepCycle();
        checkOutput("multi_stop_run", 32'(bus.running), 32'd1);
        checkOutput("multi_stop_ack", 32'(bus.ack),     32'd0);
        bus.req = 4'b0100;
        stepCycle();
        checkOutput("multi_resume_clk", 32'(bus.clk_out), 32'd1);
        checkOutput("multi_resume_ack", 32'(bus.ack),     32'b0100);

        // randomized traffic with one mid-run reset
        for (int i = 0; i < 4000; i++) begin
            stepCycle();
            if (i == 2000) begin
                #2 rst_n = 1'b0;
            end
            if (i == 2003) rst_n = 1'b1;
            if ($urandom_range(0, 15) == 0) begin
                idx = int'($urandom_range(0, 3));
                bus.req[idx] = ~bus.req[idx];
            end
            if ($urandom_range(0, 63) == 0) bus.req = 4'b0000;
            bus.div_load = ($urandom_range(0, 19) == 0);
            bus.div_val  = 8'($urandom_range(0, 4));
        end
        bus.div_load = 1'b0;
        stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
